// File: rtl/fanout_group_sched_if.sv
// rtl/fanout_group_sched_if.sv - source handshake and load bus of the fanout scheduler
interface fanout_group_sched_if #(
    parameter int NUM_LOADS = 8,
    parameter int DW        = 4,
    parameter int GW        = 1
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic [NUM_LOADS-1:0] load_en;
    logic [DW-1:0]        load_data;
    logic [NUM_LOADS-1:0] load_ack;
    logic                 busy;
    logic                 done;
    logic [NUM_LOADS-1:0] miss_mask;
    logic [GW-1:0]        grp_idx;

    modport master (
        output in_valid, in_data, load_ack,
        input  in_ready, load_en, load_data, busy, done, miss_mask, grp_idx
    );

    modport slave (
        input  in_valid, in_data, load_ack,
        output in_ready, load_en, load_data, busy, done, miss_mask, grp_idx
    );
endinterface

// File: rtl/fanout_group_sched.sv
// rtl/fanout_group_sched.sv - broadcasts one word to NUM_LOADS loads, GROUP loads at a time
module fanout_group_sched #(
    parameter int NUM_LOADS = 8,
    parameter int GROUP     = 4,
    parameter int DW        = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    fanout_group_sched_if.slave   bus
);
    localparam int NGRP = (NUM_LOADS + GROUP - 1) / GROUP;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRP, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        load_data_q, load_data_d;
    logic [NUM_LOADS-1:0] load_en_q, load_en_d;
    logic [NUM_LOADS-1:0] ack_seen_q, ack_seen_d;
    logic [NUM_LOADS-1:0] miss_mask_q, miss_mask_d;
    logic [GW-1:0]        grp_idx_q, grp_idx_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [NUM_LOADS-1:0] ack_all;
    logic                 grp_complete;
    logic                 grp_timeout;
    logic                 last_grp;

    // Loads of group g; the last group is naturally clipped at NUM_LOADS.
    function automatic logic [NUM_LOADS-1:0] grp_mask(input logic [GW-1:0] g);
        logic [NUM_LOADS-1:0] m;
        for (int i = 0; i < NUM_LOADS; i++) begin
            m[i] = ((i / GROUP) == int'(g));
        end
        return m;
    endfunction

    always_comb begin
        ack_all      = ack_seen_q | (bus.load_ack & load_en_q);
        grp_complete = (ack_all == load_en_q);
        grp_timeout  = (cnt_q == CNT_LAST) && !grp_complete;
        last_grp     = (grp_idx_q == GW'(NGRP - 1));

        state_d     = state_q;
        load_data_d = load_data_q;
        load_en_d   = load_en_q;
        ack_seen_d  = ack_seen_q;
        miss_mask_d = miss_mask_q;
        grp_idx_d   = grp_idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d    = 1'b0;
                load_en_d = '0;
                if (bus.in_valid) begin
                    load_data_d = bus.in_data;
                    miss_mask_d = '0;
                    ack_seen_d  = '0;
                    grp_idx_d   = '0;
                    cnt_d       = '0;
                    load_en_d   = grp_mask('0);
                    busy_d      = 1'b1;
                    state_d     = S_GRP;
                end
            end
            S_GRP: begin
                if (grp_complete || grp_timeout) begin
                    // Completion wins over timeout, so misses only accrue on a real timeout.
                    if (grp_timeout) begin
                        miss_mask_d = miss_mask_q | (load_en_q & ~ack_all);
                    end
                    ack_seen_d = '0;
                    cnt_d      = '0;
                    if (last_grp) begin
                        load_en_d = '0;
                        done_d    = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        grp_idx_d = grp_idx_q + 1'b1;
                        load_en_d = grp_mask(grp_idx_q + 1'b1);
                    end
                end else begin
                    ack_seen_d = ack_all;
                    cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            load_data_q <= '0;
            load_en_q   <= '0;
            ack_seen_q  <= '0;
            miss_mask_q <= '0;
            grp_idx_q   <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
            load_en_q   <= load_en_d;
            ack_seen_q  <= ack_seen_d;
            miss_mask_q <= miss_mask_d;
            grp_idx_q   <= grp_idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.load_en   = load_en_q;
    assign bus.load_data = load_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.miss_mask = miss_mask_q;
    assign bus.grp_idx   = grp_idx_q;
endmodule

// File: tb/tb_fanout_group_sched.sv
// tb/tb_fanout_group_sched.sv - randomized bench for fanout_group_sched (8 loads T=4, 6 loads T=5)
module tb_fanout_group_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fanout_group_sched_if #(.NUM_LOADS(8), .DW(4), .GW(1)) ifa ();
    fanout_group_sched_if #(.NUM_LOADS(6), .DW(4), .GW(1)) ifb ();

    fanout_group_sched #(.NUM_LOADS(8), .GROUP(4), .DW(4), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    fanout_group_sched #(.NUM_LOADS(6), .GROUP(4), .DW(4), .TIMEOUT(5)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;

    int          dly [8];
    bit          pls [8];
    logic [3:0]  last_data [2];
    logic [31:0] last_miss [2];

    logic [31:0] o_en, o_miss, o_grp;
    logic [3:0]  o_data;
    logic        o_ready, o_busy, o_done;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int nl_of(input int w);
        return (w == 0) ? 8 : 6;
    endfunction

    function automatic int to_of(input int w);
        return (w == 0) ? 4 : 5;
    endfunction

    function automatic logic [31:0] gmask(input int nl, input int g);
        logic [31:0] m = '0;
        for (int i = 0; i < nl; i++) if (i / 4 == g) m[i] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic v, input logic [3:0] d, input logic [31:0] ack);
        ifa.in_valid = (w == 0) && v;
        ifa.in_data  = d;
        ifa.load_ack = (w == 0) ? ack[7:0] : 8'h00;
        ifb.in_valid = (w == 1) && v;
        ifb.in_data  = d;
        ifb.load_ack = (w == 1) ? ack[5:0] : 6'h00;
    endtask

    task automatic sample(input int w);
        @(negedge clk);
        if (w == 0) begin
            o_en = 32'(ifa.load_en); o_miss = 32'(ifa.miss_mask); o_grp = 32'(ifa.grp_idx);
            o_data = ifa.load_data; o_ready = ifa.in_ready; o_busy = ifa.busy; o_done = ifa.done;
        end else begin
            o_en = 32'(ifb.load_en); o_miss = 32'(ifb.miss_mask); o_grp = 32'(ifb.grp_idx);
            o_data = ifb.load_data; o_ready = ifb.in_ready; o_busy = ifb.busy; o_done = ifb.done;
        end
    endtask

    // Group g lasts min(latest ack offset, TIMEOUT-1)+1 cycles; a load misses
    // when its ack offset lies beyond TIMEOUT-1.
    task automatic run_txn(input int w, input logic [3:0] data, input int gap);
        int nl = nl_of(w);
        int to = to_of(w);
        int ng = (nl + 3) / 4;
        int dur [4];
        logic [31:0] exp_miss = '0;
        logic [31:0] all_mask = gmask(nl, 0) | gmask(nl, 1);
        for (int g = 0; g < ng; g++) begin
            int maxd = 0;
            for (int i = g * 4; i < nl && i < g * 4 + 4; i++) if (dly[i] > maxd) maxd = dly[i];
            dur[g] = ((maxd < to - 1) ? maxd : to - 1) + 1;
        end
        for (int i = 0; i < nl; i++) if (dly[i] > to - 1) exp_miss[i] = 1'b1;

        for (int k = 0; k < gap; k++) begin
            step();
            drive(w, 1'b0, 4'($urandom), $urandom & all_mask);
            sample(w);
            check_val("idle_ready", 32'(o_ready), 1);
            check_val("idle_busy", 32'(o_busy), 0);
            check_val("idle_en", o_en, 0);
            check_val("idle_data", 32'(o_data), 32'(last_data[w]));
            check_val("idle_miss", o_miss, last_miss[w]);
        end
        step();
        drive(w, 1'b1, data, $urandom & all_mask);
        sample(w);
        check_val("acc_ready", 32'(o_ready), 1);
        check_val("acc_done", 32'(o_done), 0);
        check_val("acc_en", o_en, 0);
        for (int g = 0; g < ng; g++) begin
            logic [31:0] m = gmask(nl, g);
            for (int j = 0; j < dur[g]; j++) begin
                logic [31:0] ack = $urandom & ~m & all_mask;
                for (int i = 0; i < nl; i++)
                    if (m[i]) ack[i] = pls[i] ? (j == dly[i]) : (j >= dly[i]);
                step();
                drive(w, 1'($urandom), 4'($urandom), ack);
                sample(w);
                check_val("grp_en", o_en, m);
                check_val("grp_idx", o_grp, 32'(g));
                check_val("grp_busy", 32'(o_busy), 1);
                check_val("grp_ready", 32'(o_ready), 0);
                check_val("grp_done", 32'(o_done), 0);
                check_val("grp_data", 32'(o_data), 32'(data));
            end
        end
        step();
        drive(w, 1'($urandom), 4'($urandom), $urandom & all_mask);
        sample(w);
        check_val("done_pulse", 32'(o_done), 1);
        check_val("done_en", o_en, 0);
        check_val("done_busy", 32'(o_busy), 1);
        check_val("done_ready", 32'(o_ready), 0);
        check_val("done_miss", o_miss, exp_miss);
        check_val("done_data", 32'(o_data), 32'(data));
        last_data[w] = data;
        last_miss[w] = exp_miss;
    endtask

    task automatic set_all(input int d, input bit p);
        for (int i = 0; i < 8; i++) begin
            dly[i] = d;
            pls[i] = p;
        end
    endtask

    initial begin
        last_data[0] = '0; last_data[1] = '0;
        last_miss[0] = '0; last_miss[1] = '0;
        rst = 1'b1;
        ifa.in_valid = 1'b1; ifa.in_data = 4'h5; ifa.load_ack = '0;
        ifb.in_valid = 1'b1; ifb.in_data = 4'h5; ifb.load_ack = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            sample(0);
            check_val("rst_en_a", o_en, 0);
            check_val("rst_ready_a", 32'(o_ready), 0);
            sample(1);
            check_val("rst_ready_b", 32'(o_ready), 0);
        end
        rst = 1'b0;
        drive(0, 1'b0, 4'h0, 0);
        #1;
        for (int w = 0; w < 2; w++) begin
            sample(w);
            check_val("rel_ready", 32'(o_ready), 1);
            check_val("rel_busy", 32'(o_busy), 0);
            check_val("rel_done", 32'(o_done), 0);
            check_val("rel_data", 32'(o_data), 0);
            check_val("rel_miss", o_miss, 0);
            check_val("rel_grp", o_grp, 0);
        end

        // nominal, staggered pulses, timeout on load 6, completion exactly at the timeout cycle
        set_all(0, 0);
        run_txn(0, 4'hA, 0);
        set_all(0, 1); dly[2] = 2; dly[3] = 2;
        run_txn(0, 4'h6, 1);
        set_all(0, 0); dly[6] = 99;
        run_txn(0, 4'hC, 0);
        set_all(0, 1); dly[3] = 3;
        run_txn(0, 4'h1, 0);
        set_all(0, 0);
        run_txn(1, 4'h7, 1);
        set_all(1, 1); dly[5] = 99; dly[1] = 4;
        run_txn(1, 4'h2, 0);

        for (int t = 0; t < 40; t++) begin
            int w = int'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                dly[i] = ($urandom_range(0, 6) == 0) ? 99 : int'($urandom_range(0, to_of(w) + 1));
                pls[i] = 1'($urandom);
            end
            run_txn(w, 4'($urandom), int'($urandom_range(0, 2)));
        end

        // reset in the middle of group 1 aborts without a done pulse
        step(); drive(0, 1'b1, 4'h9, 0); sample(0);
        check_val("mr_ready", 32'(o_ready), 1);
        step(); drive(0, 1'b0, 4'h0, 32'h0F); sample(0);
        check_val("mr_en0", o_en, 32'h0F);
        step(); drive(0, 1'b0, 4'h0, 0); rst = 1'b1; sample(0);
        check_val("mr_en1", o_en, 32'hF0);
        step(); rst = 1'b0; drive(0, 1'b1, 4'h3, 0); sample(0);
        check_val("mr_en_clr", o_en, 0);
        check_val("mr_busy", 32'(o_busy), 0);
        check_val("mr_done", 32'(o_done), 0);
        check_val("mr_ready2", 32'(o_ready), 1);
        step(); drive(0, 1'b0, 4'h0, 32'h0F); sample(0);
        check_val("mr_new_en", o_en, 32'h0F);
        check_val("mr_new_data", 32'(o_data), 32'h3);
        step(); drive(0, 1'b0, 4'h0, 32'hF0); sample(0);
        check_val("mr_new_en1", o_en, 32'hF0);
        step(); drive(0, 1'b0, 4'h0, 0); sample(0);
        check_val("mr_new_done", 32'(o_done), 1);
        check_val("mr_new_miss", o_miss, 0);
        last_data[0] = 4'h3; last_miss[0] = '0;
        last_data[1] = 4'h0; last_miss[1] = '0;
        set_all(0, 0);
        run_txn(1, 4'hE, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fanout_group_sched.md
Name: fanout_group_sched

Overview:
- Fanout-limited broadcast scheduler. Accepts one data word per transaction and delivers it to NUM_LOADS BLK-style loads.
- No more than GROUP loads are enabled in any cycle; each group must acknowledge before the next group is enabled.
- Sits between a single high-fanout source net and its load cells. It bounds instantaneous fanout and produces a per-load delivery/miss report.

Parameters:
- NUM_LOADS, 8, number of load endpoints (1..32)
- GROUP, 4, maximum loads enabled simultaneously (1..NUM_LOADS)
- DW, 4, data word width
- TIMEOUT, 15, max cycles a group may wait for acks (2..255)
- Derived: NGRP = ceil(NUM_LOADS/GROUP); group g covers load indices g*GROUP .. min((g+1)*GROUP, NUM_LOADS)-1.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active high
- in_valid  in  1  source word valid
- in_ready  out  1  scheduler can accept a word
- in_data  in  DW  source word
- load_en  out  NUM_LOADS  per-load enable, one-hot-group mask
- load_data  out  DW  latched word broadcast to loads
- load_ack  in  NUM_LOADS  per-load acknowledge (level or pulse)
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- miss_mask  out  NUM_LOADS  loads that timed out in last transaction
- grp_idx  out  clog2(NGRP) (min 1)  current group index, debug

Behaviour:
- Reset state (rst=1 at an edge):
  - Next cycle: state IDLE; load_en=0, load_data=0, busy=0, done=0, miss_mask=0, grp_idx=0, wait counter=0, ack_seen=0.
  - in_ready is 0 while rst is high, and 1 in the first cycle after rst is released.
  - Reset mid-transaction aborts it immediately. No done pulse is generated.
- States: IDLE, GRP, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - If in_valid & in_ready at an edge:
    - latch in_data into load_data;
    - clear miss_mask and ack_seen;
    - set grp_idx=0 and wait counter=0;
    - go to GRP.
- GRP:
  - in_ready=0, busy=1.
  - load_en equals the mask of group grp_idx. It is first asserted the cycle after acceptance (latency 1).
  - Each edge: ack_seen |= load_ack & mask. Acks outside the mask are ignored and never recorded.
  - Group complete when (ack_seen | (load_ack & mask)) == mask. An ack present in the completing cycle counts.
  - On complete:
    - if grp_idx < NGRP-1: increment grp_idx, clear ack_seen and counter. The next group's load_en is asserted in the next cycle, with no idle gap.
    - otherwise go to DONE.
  - Timeout: if the counter equals TIMEOUT-1 and the group is not complete:
    - miss_mask |= mask & ~(ack_seen | load_ack);
    - advance exactly as on complete.
  - Otherwise increment the counter (saturating).
  - Completion and timeout in the same cycle: completion wins, no miss bits set.
  - Partial last group (NUM_LOADS not a multiple of GROUP): mask covers only valid indices.
- DONE:
  - load_en=0, done=1 for exactly one cycle, busy=1, in_ready=0.
  - Next state is IDLE.
  - Minimum spacing between accepted words is NGRP+2 cycles.
- load_data holds stable from acceptance until the next acceptance. miss_mask is valid from the done cycle until the next acceptance.
- in_valid while not ready: ignored, no side effect.

Test Plan:
- Reset then idle: hold rst 3 cycles with in_valid=1 -> load_en=0, in_ready=0 during reset; in_ready=1 the cycle after release; no acceptance during reset.
- Nominal, defaults:
  - Stimulus: in_data=4'hA; loads ack in the same cycle load_en rises.
  - Response: load_en=8'h0F at cycle+1, 8'hF0 at cycle+2, done=1 at cycle+3, in_ready=1 at cycle+4, miss_mask=0, load_data=4'hA throughout.
- Staggered acks: group 0 acks bits 0,1 at cycle 1 and bits 2,3 at cycle 3 -> load_en stays 8'h0F cycles 1–3 and switches to 8'hF0 at cycle 4. A pulse on bit 5 during group 0 does not count toward group 1.
- Timeout: TIMEOUT=4, load 6 never acks -> group 1 held exactly 4 cycles, then DONE; miss_mask=8'h40, done pulses once.
- Partial group: NUM_LOADS=6, GROUP=4 -> masks 6'h0F then 6'h30; done after both complete.
- Mid-transaction reset: assert rst while load_en=8'hF0 -> next cycle load_en=0, busy=0, no done. After release, a new word 4'h3 is accepted and load_en=8'h0F one cycle later.
